// File: rtl/shapool_result_tx.sv
// rtl/shapool_result_tx.sv - captures the winning nonce, halts the pool, sends an 8N1 result frame, waits for resume
// Optional checksum byte: define SHAPOOL_RESULT_CHECKSUM_EN
module shapool_result_tx #(
    parameter int          NONCE_WIDTH  = 32,
    parameter int          CLKS_PER_BIT = 104,
    parameter logic [7:0]  DEVICE_ID    = 8'h00
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   success,
    input  logic [NONCE_WIDTH-1:0] nonce,
    input  logic                   resume,
    output logic                   tx,
    output logic                   halt_pool,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int NB     = (NONCE_WIDTH + 7) / 8;
    localparam int NBUF_W = NB * 8;
`ifdef SHAPOOL_RESULT_CHECKSUM_EN
    localparam int FB     = NB + 3;
`else
    localparam int FB     = NB + 2;
`endif
    localparam int IW     = $clog2(NB + 3);
    localparam int CW     = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(FB - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_HOLD} state_t;

    state_t              state, state_d;
    logic [CW-1:0]       baud_cnt, baud_d;
    logic [2:0]          bit_cnt, bit_d;
    logic [IW-1:0]       byte_idx, idx_d, nxt_idx;
    logic [7:0]          shreg, sh_d, next_byte;
    logic [NBUF_W-1:0]   nonce_buf, nbuf_d;
    logic                tx_d, halt_d, busy_d, done_d;
    logic                bit_end;
`ifdef SHAPOOL_RESULT_CHECKSUM_EN
    logic [7:0]          csum, csum_d;
`endif

    assign bit_end = (baud_cnt == BIT_LAST);
    assign nxt_idx = byte_idx + IW'(1);

    // Pick the byte that follows the current one: device id, nonce MSB first, then checksum
    always_comb begin
        next_byte = DEVICE_ID;
        for (int i = 0; i < NB; i++) begin
            if (nxt_idx == IW'(i + 2)) begin
                next_byte = nonce_buf[(NB-1-i)*8 +: 8];
            end
        end
`ifdef SHAPOOL_RESULT_CHECKSUM_EN
        if (nxt_idx == LAST_IDX) begin
            next_byte = csum;
        end
`endif
    end

    // State register plus datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            shreg      <= '0;
            nonce_buf  <= '0;
            tx         <= 1'b1;
            halt_pool  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef SHAPOOL_RESULT_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            state      <= state_d;
            baud_cnt   <= baud_d;
            bit_cnt    <= bit_d;
            byte_idx   <= idx_d;
            shreg      <= sh_d;
            nonce_buf  <= nbuf_d;
            tx         <= tx_d;
            halt_pool  <= halt_d;
            busy       <= busy_d;
            frame_done <= done_d;
`ifdef SHAPOOL_RESULT_CHECKSUM_EN
            csum       <= csum_d;
`endif
        end
    end

    // Next-state and datapath update; the nonce buffer only loads from IDLE
    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_cnt;
        idx_d   = byte_idx;
        sh_d    = shreg;
        nbuf_d  = nonce_buf;
`ifdef SHAPOOL_RESULT_CHECKSUM_EN
        csum_d  = csum;
`endif
        case (state)
            S_IDLE: begin
                if (success) begin
                    nbuf_d  = NBUF_W'(nonce);
                    sh_d    = 8'hA5;
                    idx_d   = '0;
                    baud_d  = '0;
                    bit_d   = '0;
`ifdef SHAPOOL_RESULT_CHECKSUM_EN
                    csum_d  = 8'hA5;
`endif
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d  = baud_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    sh_d   = shreg >> 1;
                    bit_d  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    baud_d = baud_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (byte_idx == LAST_IDX) begin
                        state_d = S_HOLD;
                    end else begin
                        idx_d   = nxt_idx;
                        sh_d    = next_byte;
`ifdef SHAPOOL_RESULT_CHECKSUM_EN
                        csum_d  = csum ^ next_byte;
`endif
                        state_d = S_START;
                    end
                end else begin
                    baud_d = baud_cnt + CW'(1);
                end
            end
            S_HOLD: begin
                if (resume) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so they land registered
    always_comb begin
        tx_d   = 1'b1;
        halt_d = (state_d != S_IDLE);
        busy_d = (state_d != S_IDLE);
        done_d = (state == S_STOP) && bit_end && (byte_idx == LAST_IDX);
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = sh_d[0];
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_shapool_result_tx.sv
// tb/tb_shapool_result_tx.sv - directed self-checking bench for shapool_result_tx
module tb_shapool_result_tx;

    localparam int CPB = 4;
`ifdef SHAPOOL_RESULT_CHECKSUM_EN
    localparam int FB = 7;
`else
    localparam int FB = 6;
`endif
    localparam int FC = FB * 10 * CPB;

    logic        clk = 1'b0;
    logic        reset, success, resume;
    logic [31:0] nonce;
    logic [29:0] nonce30;
    logic        tx32, halt32, busy32, done32;
    logic        tx30, halt30, busy30, done30;

    int total = 0;
    int bad   = 0;

    logic       r32 [0:FC-1];
    logic       r30 [0:FC-1];
    logic [7:0] e32 [0:6];
    logic [7:0] e30 [0:6];

    shapool_result_tx #(.NONCE_WIDTH(32), .CLKS_PER_BIT(CPB), .DEVICE_ID(8'h01)) dut32 (
        .clk(clk), .reset(reset), .success(success), .nonce(nonce), .resume(resume),
        .tx(tx32), .halt_pool(halt32), .busy(busy32), .frame_done(done32)
    );

    shapool_result_tx #(.NONCE_WIDTH(30), .CLKS_PER_BIT(CPB), .DEVICE_ID(8'h01)) dut30 (
        .clk(clk), .reset(reset), .success(success), .nonce(nonce30), .resume(resume),
        .tx(tx30), .halt_pool(halt30), .busy(busy30), .frame_done(done30)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_exp(input logic [31:0] n32, input logic [7:0] c32,
                           input logic [31:0] n30, input logic [7:0] c30);
        e32[0] = 8'hA5; e32[1] = 8'h01;
        e32[2] = n32[31:24]; e32[3] = n32[23:16]; e32[4] = n32[15:8]; e32[5] = n32[7:0];
        e32[6] = c32;
        e30[0] = 8'hA5; e30[1] = 8'h01;
        e30[2] = n30[31:24]; e30[3] = n30[23:16]; e30[4] = n30[15:8]; e30[5] = n30[7:0];
        e30[6] = c30;
    endtask

    // Called one cycle after the capture edge; records the whole frame. inj>0 pulses a
    // competing success at cycle inj and a stray resume at cycle inj+20.
    task automatic run_frame(input string tag, input int inj);
        int early_done;
        int halt_drop;
        early_done = 0;
        halt_drop  = 0;
        for (int c = 0; c < FC; c++) begin
            r32[c] = tx32;
            r30[c] = tx30;
            if (done32 !== 1'b0 || done30 !== 1'b0) early_done++;
            if (halt32 !== 1'b1 || halt30 !== 1'b1) halt_drop++;
            success = (inj > 0) && (c == inj);
            resume  = (inj > 0) && (c == inj + 20);
            if (c == inj) begin
                nonce   = 32'hDEADBEEF;
                nonce30 = 30'h0;
            end
            tick();
        end
        success = 1'b0;
        resume  = 1'b0;
        check({tag, "_no_early_done"}, early_done, 0);
        check({tag, "_halt_held"}, halt_drop, 0);
        check({tag, "_done32"}, done32, 1'b1);
        check({tag, "_done30"}, done30, 1'b1);
        check({tag, "_hold_halt"}, halt32, 1'b1);
        tick();
        check({tag, "_done_one_cycle"}, done32, 1'b0);
        check({tag, "_hold_busy"}, busy32, 1'b1);
        check({tag, "_hold_tx"}, tx32, 1'b1);
    endtask

    task automatic decode(input string tag, input int which);
        logic [7:0] byt;
        logic       v;
        int framing;
        int unstable;
        framing  = 0;
        unstable = 0;
        for (int k = 0; k < FB; k++) begin
            byt = 8'h00;
            for (int b = 0; b < 10; b++) begin
                int base;
                base = (k * 10 + b) * CPB;
                v = (which == 1) ? r30[base] : r32[base];
                for (int s = 1; s < CPB; s++) begin
                    if (((which == 1) ? r30[base+s] : r32[base+s]) !== v) unstable++;
                end
                if (b == 0 && v !== 1'b0) framing++;
                if (b == 9 && v !== 1'b1) framing++;
                if (b >= 1 && b <= 8) byt[b-1] = v;
            end
            check($sformatf("%s_byte%0d", tag, k), byt, (which == 1) ? e30[k] : e32[k]);
        end
        check({tag, "_framing"}, framing, 0);
        check({tag, "_bit_width"}, unstable, 0);
    endtask

    initial begin
        reset   = 1'b1;
        success = 1'b0;
        resume  = 1'b0;
        nonce   = 32'h0;
        nonce30 = 30'h0;
        tick();
        tick();
        check("rst_tx", tx32, 1'b1);
        check("rst_halt", halt32, 1'b0);
        check("rst_busy", busy32, 1'b0);
        check("rst_done", done32, 1'b0);
        check("rst_tx30", tx30, 1'b1);
        reset = 1'b0;
        tick();
        check("idle_tx", tx32, 1'b1);

        // Frame 1: basic capture, with mid-frame success and resume that must be ignored
        nonce   = 32'h000001F3;
        nonce30 = 30'h3FFFFFFF;
        success = 1'b1;
        tick();
        success = 1'b0;
        check("f1_start_tx", tx32, 1'b0);
        check("f1_start_busy", busy32, 1'b1);
        check("f1_start_halt", halt32, 1'b1);
        run_frame("f1", 50);
        set_exp(32'h000001F3, 8'h56, 32'h3FFFFFFF, 8'h64);
        decode("f1_n32", 0);
        decode("f1_n30", 1);
        repeat (5) tick();
        check("f1_hold_no_memory", halt32, 1'b1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("f1_resume_halt", halt32, 1'b0);
        check("f1_resume_busy", busy32, 1'b0);

        // Reset in the data bits of the third byte, then a fresh frame
        nonce   = 32'h11111111;
        nonce30 = 30'h11111111;
        success = 1'b1;
        tick();
        success = 1'b0;
        repeat (90) tick();
        check("mid_busy_before_rst", busy32, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_tx", tx32, 1'b1);
        check("mid_rst_busy", busy32, 1'b0);
        check("mid_rst_halt", halt32, 1'b0);
        check("mid_rst_done", done32, 1'b0);
        check("mid_rst_busy30", busy30, 1'b0);
        tick();
        check("mid_rst_still_idle", busy32, 1'b0);
        nonce   = 32'h12345678;
        nonce30 = 30'h0ABCDEF0;
        success = 1'b1;
        tick();
        success = 1'b0;
        check("f2_start_tx", tx32, 1'b0);
        run_frame("f2", 0);
        set_exp(32'h12345678, 8'hAC, 32'h0ABCDEF0, 8'h3C);
        decode("f2_n32", 0);
        decode("f2_n30", 1);

        // resume and success together in HOLD: leave without capture, capture one cycle later
        nonce   = 32'hCAFEF00D;
        nonce30 = 30'h0;
        success = 1'b1;
        resume  = 1'b1;
        tick();
        resume  = 1'b0;
        check("rs_idle_busy", busy32, 1'b0);
        check("rs_idle_halt", halt32, 1'b0);
        check("rs_idle_tx", tx32, 1'b1);
        tick();
        success = 1'b0;
        check("rs_capture_tx", tx32, 1'b0);
        check("rs_capture_busy", busy32, 1'b1);
        run_frame("f3", 0);
        set_exp(32'hCAFEF00D, 8'h6D, 32'h00000000, 8'hA4);
        decode("f3_n32", 0);
        decode("f3_n30", 1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("end_idle_busy", busy32, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shapool_result_tx.md
# shapool_result_tx

Downstream result stage for the hashing pool. It captures the winning nonce when the pool reports success and holds the pool halted. It then transmits a framed result over an 8N1 UART-style serial line and waits for a host resume before releasing the pool. It sits between the `shapool` results (`success`, `nonce`) and the board TX pin, and it replaces the ad-hoc LED/result latch used in single-device bring-up tops.

## Interface

Parameters:
- `NONCE_WIDTH`, 32: width of the pool nonce output (`32 - POOL_SIZE_LOG2`); 1..32.
- `CLKS_PER_BIT`, 104: `clk` cycles per serial bit; must be ≥2.
- `DEVICE_ID`, 8'h00: byte identifying this device in the frame.

Ports:
- `clk`  in  1  system clock (PLL output). One clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `success`  in  1  pool success flag; `nonce` is valid while it is high.
- `nonce`  in  NONCE_WIDTH  winning nonce from the pool.
- `resume`  in  1  host acknowledge; single-cycle pulse or level.
- `tx`  out  1  serial output; idle high.
- `halt_pool`  out  1  OR'd into the pool reset by the top; high from capture until resume.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse after the last stop bit.

## Operation

- Frame bytes, in order:
  - header 8'hA5
  - `DEVICE_ID`
  - nonce, zero-extended to NB = ceil(NONCE_WIDTH/8) bytes, most-significant byte first
  - optional checksum (see Configuration)
- Each byte goes out as a start bit (0), 8 data bits LSB first, then a stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles. There is no gap between bytes.
- States:
  - IDLE: `tx`=1. If `success`=1, latch `nonce` into the shift buffer, load the header byte, clear the byte index and go to START.
  - START: `tx`=0 for one bit period, then go to DATA.
  - DATA: shift out 8 bits, then go to STOP.
  - STOP: `tx`=1 for one bit period. If bytes remain, load the next byte and go to START. Otherwise pulse `frame_done` and go to HOLD.
  - HOLD: `tx`=1, `halt_pool`=1. On `resume`=1, go to IDLE.
- Counters:
  - Bit-time counter: width ceil(log2(CLKS_PER_BIT)); reloads at each bit boundary.
  - Bit counter: 3 bits.
  - Byte index: wide enough for NB+3 values.
- `success` outside IDLE is ignored. The latched nonce is never overwritten mid-frame.
- `resume` outside HOLD is ignored. It is not remembered.
- `success` and `resume` high in the same cycle while in HOLD: leave for IDLE. The success is not captured. The pool is still halted that cycle, so no result is lost.
- Reset at any time, including mid-frame:
  - next state IDLE; `tx`=1, `halt_pool`=0, `busy`=0, `frame_done`=0
  - nonce buffer cleared to 0
  - no partial frame is completed

## Timing

- All outputs are registered.
- Reset values: `tx`=1, `halt_pool`=0, `busy`=0, `frame_done`=0.
- `success` sampled high at edge N:
  - from N+1, `tx`=0 (start bit of the header), `busy`=1 and `halt_pool`=1
  - the pool stops within one cycle of reporting
- Frame length with F bytes: F·10·CLKS_PER_BIT cycles from N+1 through the last stop bit.
- `frame_done` is high for exactly the single cycle following the last stop-bit cycle. HOLD is entered in that same cycle.
- `resume` sampled high at edge M in HOLD: `halt_pool`=0 and `busy`=0 from M+1.
- A new `success` can be captured at edge M+1 at the earliest.

## Configuration

- `SHAPOOL_RESULT_CHECKSUM_EN`
  - Defined: one extra byte is appended after the nonce. It is the XOR of every preceding frame byte, header included. F = NB+3.
  - Undefined: no checksum byte is sent. F = NB+2. The checksum logic is absent.

## Test plan

- Capture with NONCE_WIDTH=32, CLKS_PER_BIT=4, DEVICE_ID=8'h01, nonce 32'h000001F3, macro undefined: decoded bytes are A5 01 00 00 01 F3. `tx` is low at N+1. `frame_done` pulses at N+241.
- Same stimulus with `SHAPOOL_RESULT_CHECKSUM_EN` defined: bytes are A5 01 00 00 01 F3 56. `frame_done` pulses at N+281.
- NONCE_WIDTH=30, nonce 30'h3FFFFFFF: nonce bytes are 3F FF FF FF, with the top two bits zero-padded.
- Second `success` pulse mid-frame with a different nonce: frame content is unchanged. `halt_pool` stays 1 until `resume` in HOLD. `resume` pulsed mid-frame has no effect.
- `reset` asserted during the DATA state of byte 3: the next cycle shows `tx`=1, `busy`=0, `halt_pool`=0. A following `success` starts a fresh full frame.
- `resume` and `success` together in HOLD: the next state is IDLE with no capture. `success` one cycle later is captured and a new frame starts.
